shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have no parameters; data width is fixed at 32 and shift amount at 5 bits.
REQ-002 SHALL have port: clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-low reset, sampled on the clock edge.
REQ-004 SHALL have port: req_valid_n (n=0,1)  in  1  requester n presents a shift request.
REQ-005 SHALL have port: req_ready_n (n=0,1)  out  1  request n accepted this cycle.
REQ-006 SHALL have port: req_data_n (n=0,1)  in  32  operand to shift.
REQ-007 SHALL have port: req_amt_n (n=0,1)  in  5  shift amount 0..31.
REQ-008 SHALL have port: req_op_n (n=0,1)  in  1  0=SLL, 1=SRA.
REQ-009 SHALL have port: resp_valid_n (n=0,1)  out  1  result ready for requester n.
REQ-010 SHALL have port: resp_ready_n (n=0,1)  in  1  requester n consumes result.
REQ-011 SHALL have port: resp_data  out  32  result, shared by both requesters, qualified by resp_valid_n.
REQ-012 SHALL have port: busy  out  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; one request in flight at a time.
REQ-014 IDLE: req_ready_n SHALL be combinational: high only for the granted requester when its req_valid_n is high; handshake = valid & ready.
REQ-015 Arbitration SHALL be round-robin: if both valid, grant the requester not granted last; if one valid, grant it.
REQ-016 On handshake, SHALL latch data, amount, op and requester id, update last_grant, and go to EXEC.
REQ-017 EXEC: SHALL compute the shift through the core and register it into the result register; go to DONE (exactly one cycle).
REQ-018 DONE: resp_valid for the latched id SHALL be high; the other resp_valid SHALL be low; resp_data SHALL stay stable until resp_ready for that id is sampled high, then return to IDLE.
REQ-019 Latency SHALL be accept at cycle N, resp_valid high from cycle N+2; back-to-back accept no earlier than the cycle after response handshake (min 3 cycles per op).
REQ-020 SLL SHALL zero-fill from bit 0; SRA SHALL replicate bit 31; amount 0 SHALL return operand unchanged; amount 31 SHALL be legal.
REQ-021 req_ready_n SHALL be low in EXEC and DONE regardless of req_valid_n; pending requests wait and are not dropped.
REQ-022 resp_ready of the non-owning requester SHALL be ignored.

Reset
REQ-023 With reset low at a clock edge: state=IDLE, last_grant=1 (requester 0 wins first tie), result register=0, latched operands=0.
REQ-024 After reset, all req_ready_n=0 until a valid arrives, resp_valid_n=0, resp_data=0, busy=0.
REQ-025 Reset asserted in EXEC or DONE SHALL abort the operation; no response is ever issued for it.

Configuration
REQ-026 Macro SHIFT_ARBITER_SRA_EN: defined -> req_op_n honoured per REQ-020; undefined -> req_op_n ignored, every request performs SLL, and no SRA logic is synthesized.

Structure
REQ-027 Shared package shift_pkg SHALL hold the op encoding (OP_SLL=0, OP_SRA=1), FSM state typedef (IDLE, EXEC, DONE) and width constants (DATA_W=32, AMT_W=5).
REQ-028 One sub-module, shift_core: combinational 5-stage log shifter (16/8/4/2/1) with op input; the arbiter holds all sequential logic.

Verification
REQ-029 Req0 only: data=0x0000_0001, amt=31, op=SLL -> resp_valid_0 at N+2, resp_data=0x8000_0000.
REQ-030 Both valid in IDLE after reset -> req0 granted first; next tie -> req1; alternation continues over 4 ops.
REQ-031 SRA data=0x8000_00F0, amt=4 -> 0xF800_000F (macro defined); same stimulus macro undefined -> SLL result 0x0000_0F00.
REQ-032 amt=0, data=0xDEAD_BEEF -> 0xDEAD_BEEF; resp_ready_0 held low 5 cycles -> resp_valid_0 and data held stable, req_ready_1 stays 0.
REQ-033 Reset low during EXEC -> next cycle busy=0, no resp_valid pulse; new request then completes normally.
REQ-034 resp_ready_1 high while owner is req0 in DONE -> FSM stays in DONE.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: data/amount widths, op encoding and FSM states.
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    localparam logic OP_SLL = 1'b0;
    localparam logic OP_SRA = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_core.sv
// Combinational 5-stage logarithmic shifter (16/8/4/2/1 bit stages).
// Build option SHIFT_ARBITER_SRA_EN adds arithmetic right shift; without it every shift is SLL.
module shift_core
    import shift_pkg::*;
(
    input  logic [31:0] data,
    input  logic [4:0]  amt,
    input  logic        op,
    output logic [31:0] result
);

`ifdef SHIFT_ARBITER_SRA_EN
    logic arith;
    assign arith = (op == OP_SRA);

    // Each stage re-reads bit 31 of its own input, so the sign keeps propagating through later stages.
    function automatic logic [DATA_W-1:0] shift_by(input logic [DATA_W-1:0] v, input int k,
                                                   input logic right);
        logic signed [DATA_W-1:0] sv;
        sv = v;
        if (right) begin
            return sv >>> k;
        end
        return v << k;
    endfunction

    always_comb begin
        result = data;
        for (int i = 0; i < AMT_W; i++) begin
            if (amt[AMT_W-1-i]) begin
                result = shift_by(result, 16 >> i, arith);
            end
        end
    end
`else
    logic unused_op;
    assign unused_op = op;

    always_comb begin
        result = data;
        for (int i = 0; i < AMT_W; i++) begin
            if (amt[AMT_W-1-i]) begin
                result = result << (16 >> i);
            end
        end
    end
`endif

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for a shared shifter, one operation in flight (IDLE -> EXEC -> DONE).
// Define SHIFT_ARBITER_SRA_EN to honour req_op_n; otherwise req_op_n is ignored and every request is SLL.
module shift_arbiter
    import shift_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic [31:0] req_data_0,
    input  logic [4:0]  req_amt_0,
    input  logic        req_op_0,
    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic [31:0] req_data_1,
    input  logic [4:0]  req_amt_1,
    input  logic        req_op_1,
    output logic        resp_valid_0,
    input  logic        resp_ready_0,
    output logic        resp_valid_1,
    input  logic        resp_ready_1,
    output logic [31:0] resp_data,
    output logic        busy
);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        id_q, id_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  amt_q, amt_d;
    logic [31:0] result_q, result_d;
    logic        core_op;
    logic [31:0] core_result;
    logic        grant;

`ifdef SHIFT_ARBITER_SRA_EN
    logic op_q, op_d;
    assign core_op = op_q;
`else
    logic unused_req_op;
    assign unused_req_op = req_op_0 ^ req_op_1;
    assign core_op       = OP_SLL;
`endif

    shift_core u_core (
        .data   (data_q),
        .amt    (amt_q),
        .op     (core_op),
        .result (core_result)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        data_d       = data_q;
        amt_d        = amt_q;
        result_d     = result_q;
`ifdef SHIFT_ARBITER_SRA_EN
        op_d         = op_q;
`endif
        grant        = 1'b0;
        req_ready_0  = 1'b0;
        req_ready_1  = 1'b0;
        resp_valid_0 = 1'b0;
        resp_valid_1 = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the requester that did not win last time goes first.
                if (req_valid_0 && req_valid_1) begin
                    grant = ~last_grant_q;
                end else begin
                    grant = req_valid_1;
                end
                req_ready_0 = req_valid_0 && !grant;
                req_ready_1 = req_valid_1 && grant;
                if (req_ready_0 || req_ready_1) begin
                    state_d      = EXEC;
                    last_grant_d = grant;
                    id_d         = grant;
                    data_d       = grant ? req_data_1 : req_data_0;
                    amt_d        = grant ? req_amt_1 : req_amt_0;
`ifdef SHIFT_ARBITER_SRA_EN
                    op_d         = grant ? req_op_1 : req_op_0;
`endif
                end
            end
            EXEC: begin
                result_d = core_result;
                state_d  = DONE;
            end
            DONE: begin
                resp_valid_0 = !id_q;
                resp_valid_1 = id_q;
                if (id_q ? resp_ready_1 : resp_ready_0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            data_q       <= '0;
            amt_q        <= '0;
            result_q     <= '0;
`ifdef SHIFT_ARBITER_SRA_EN
            op_q         <= OP_SLL;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            data_q       <= data_d;
            amt_q        <= amt_d;
            result_q     <= result_d;
`ifdef SHIFT_ARBITER_SRA_EN
            op_q         <= op_d;
`endif
        end
    end

    assign resp_data = result_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus randomized traffic against a shift/round-robin model.
module tb_shift_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
    logic        req_ready_0, req_ready_1;
    logic [31:0] req_data_0 = '0, req_data_1 = '0;
    logic [4:0]  req_amt_0 = '0, req_amt_1 = '0;
    logic        req_op_0 = 1'b0, req_op_1 = 1'b0;
    logic        resp_valid_0, resp_valid_1;
    logic        resp_ready_0 = 1'b0, resp_ready_1 = 1'b0;
    logic [31:0] resp_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    shift_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid_0  (req_valid_0),
        .req_ready_0  (req_ready_0),
        .req_data_0   (req_data_0),
        .req_amt_0    (req_amt_0),
        .req_op_0     (req_op_0),
        .req_valid_1  (req_valid_1),
        .req_ready_1  (req_ready_1),
        .req_data_1   (req_data_1),
        .req_amt_1    (req_amt_1),
        .req_op_1     (req_op_1),
        .resp_valid_0 (resp_valid_0),
        .resp_ready_0 (resp_ready_0),
        .resp_valid_1 (resp_valid_1),
        .resp_ready_1 (resp_ready_1),
        .resp_data    (resp_data),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    // Reference: plain shift operators on the operand.
    function automatic logic [31:0] model(input logic [31:0] d, input int a, input bit op);
        logic signed [31:0] sd;
        sd = d;
`ifdef SHIFT_ARBITER_SRA_EN
        if (op) return sd >>> a;
`endif
        return d << a;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input bit id, input bit v, input logic [31:0] d, input logic [4:0] a, input bit op);
        if (!id) begin
            req_valid_0 = v; req_data_0 = d; req_amt_0 = a; req_op_0 = op;
        end else begin
            req_valid_1 = v; req_data_1 = d; req_amt_1 = a; req_op_1 = op;
        end
    endtask

    task automatic clear_inputs();
        set_req(0, 0, '0, '0, 0);
        set_req(1, 0, '0, '0, 0);
        resp_ready_0 = 0;
        resp_ready_1 = 0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    // Drives one request alone; lat counts clock edges from the accepting edge to resp_valid.
    task automatic issue(input bit id, input logic [31:0] d, input logic [4:0] a, input bit op,
                         output int lat, output logic [31:0] rd, output bit ok);
        int n;
        ok = 1; lat = -1; rd = '0;
        set_req(id, 1, d, a, op);
        #1;
        n = 0;
        while (!(id ? req_ready_1 : req_ready_0) && n < 20) begin tick(); n++; end
        if (n >= 20) begin ok = 0; set_req(id, 0, '0, '0, 0); return; end
        tick();
        set_req(id, 0, '0, '0, 0);
        lat = 1;
        while (!(id ? resp_valid_1 : resp_valid_0) && lat < 20) begin tick(); lat++; end
        if (lat >= 20) begin ok = 0; return; end
        rd = resp_data;
        if (!id) resp_ready_0 = 1; else resp_ready_1 = 1;
        tick();
        resp_ready_0 = 0;
        resp_ready_1 = 0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (resp_valid_0 !== 1'b0 || resp_valid_1 !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b%b expected 00", resp_valid_1, resp_valid_0); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 00000000", resp_data); end
        checks++; if (req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b%b expected 00", req_ready_1, req_ready_0); end
    endtask

    task automatic test_sll_boundary();
        int lat; logic [31:0] rd; bit ok;
        issue(0, 32'h0000_0001, 5'd31, 0, lat, rd, ok);
        checks++; if (!ok) begin errors++; $display("FAIL sll31_timeout: got timeout expected response"); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL sll31_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'h8000_0000) begin errors++; $display("FAIL sll31_data: got %h expected 80000000", rd); end
        issue(1, 32'h8000_0000, 5'd31, 1, lat, rd, ok);
        checks++; if (!ok || rd !== model(32'h8000_0000, 31, 1)) begin errors++; $display("FAIL amt31_op1: got %h expected %h", rd, model(32'h8000_0000, 31, 1)); end
    endtask

    task automatic test_sra();
        int lat; logic [31:0] rd; bit ok; logic [31:0] exp;
`ifdef SHIFT_ARBITER_SRA_EN
        exp = 32'hF800_000F;
`else
        exp = 32'h0000_0F00;
`endif
        issue(0, 32'h8000_00F0, 5'd4, 1, lat, rd, ok);
        checks++; if (!ok || rd !== exp) begin errors++; $display("FAIL sra_data: got %h expected %h", rd, exp); end
    endtask

    task automatic test_round_robin();
        logic [31:0] fd [2]; logic [4:0] fa [2]; bit fo [2];
        bit last, g; int n; logic [31:0] exp;
        reset_dut();
        for (int i = 0; i < 2; i++) begin
            fd[i] = $urandom; fa[i] = 5'($urandom_range(0, 31)); fo[i] = 1'($urandom_range(0, 1));
            set_req(1'(i), 1, fd[i], fa[i], fo[i]);
        end
        last = 1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(req_ready_0 || req_ready_1) && n < 20) begin tick(); n++; end
            checks++; if (n >= 20) begin errors++; $display("FAIL rr_grant_timeout: got no ready expected a grant"); break; end
            g = req_ready_1;
            checks++; if (g !== ~last || (req_ready_0 && req_ready_1)) begin errors++; $display("FAIL rr_grant: got ready=%b%b expected requester %0d", req_ready_1, req_ready_0, ~last); end
            exp = model(fd[g], fa[g], fo[g]);
            last = g;
            tick();
            fd[g] = $urandom; fa[g] = 5'($urandom_range(0, 31)); fo[g] = 1'($urandom_range(0, 1));
            set_req(g, 1, fd[g], fa[g], fo[g]);
            #1;
            n = 0;
            while (!(g ? resp_valid_1 : resp_valid_0) && n < 10) begin tick(); n++; end
            checks++; if (n >= 10) begin errors++; $display("FAIL rr_resp_timeout: got no resp_valid expected one"); break; end
            checks++; if (resp_data !== exp) begin errors++; $display("FAIL rr_data: got %h expected %h", resp_data, exp); end
            checks++; if (req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0) begin errors++; $display("FAIL rr_ready_in_done: got %b%b expected 00", req_ready_1, req_ready_0); end
            resp_ready_0 = 1; resp_ready_1 = 1;
            tick();
            resp_ready_0 = 0; resp_ready_1 = 0;
        end
        clear_inputs();
    endtask

    task automatic test_hold();
        int n; logic [31:0] exp;
        exp = 32'hDEAD_BEEF;
        set_req(0, 1, 32'hDEAD_BEEF, 5'd0, 0);
        #1;
        n = 0;
        while (!req_ready_0 && n < 20) begin tick(); n++; end
        tick();
        set_req(0, 0, '0, '0, 0);
        set_req(1, 1, 32'h0000_0003, 5'd2, 0);
        n = 0;
        #1;
        while (!resp_valid_0 && n < 10) begin tick(); n++; end
        for (int h = 0; h < 5; h++) begin
            checks++; if (resp_valid_0 !== 1'b1 || resp_valid_1 !== 1'b0) begin errors++; $display("FAIL hold_valid: got %b%b expected 01", resp_valid_1, resp_valid_0); end
            checks++; if (resp_data !== exp) begin errors++; $display("FAIL hold_data: got %h expected %h", resp_data, exp); end
            checks++; if (req_ready_1 !== 1'b0) begin errors++; $display("FAIL hold_ready1: got %b expected 0", req_ready_1); end
            tick();
        end
        resp_ready_0 = 1;
        tick();
        resp_ready_0 = 0;
        checks++; if (req_ready_1 !== 1'b1) begin errors++; $display("FAIL pending_req1: got %b expected 1", req_ready_1); end
        tick();
        set_req(1, 0, '0, '0, 0);
        n = 0;
        while (!resp_valid_1 && n < 10) begin tick(); n++; end
        checks++; if (resp_valid_1 !== 1'b1 || resp_data !== 32'h0000_000C) begin errors++; $display("FAIL pending_data: got %h valid %b expected 0000000c valid 1", resp_data, resp_valid_1); end
        resp_ready_1 = 1;
        tick();
        resp_ready_1 = 0;
    endtask

    task automatic test_reset_exec();
        int n, lat; logic [31:0] rd; bit ok; bit seen;
        set_req(0, 1, 32'h1234_5678, 5'd8, 0);
        #1;
        n = 0;
        while (!req_ready_0 && n < 20) begin tick(); n++; end
        tick();
        set_req(0, 0, '0, '0, 0);
        reset = 0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL abort_data: got %h expected 00000000", resp_data); end
        reset = 1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid_0 || resp_valid_1) seen = 1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_resp: got a resp_valid pulse expected none"); end
        issue(1, 32'h0000_00FF, 5'd4, 0, lat, rd, ok);
        checks++; if (!ok || lat !== 2 || rd !== 32'h0000_0FF0) begin errors++; $display("FAIL after_abort: got %h lat %0d expected 00000ff0 lat 2", rd, lat); end
    endtask

    task automatic test_wrong_owner();
        int n;
        set_req(0, 1, 32'h0000_0005, 5'd1, 0);
        #1;
        n = 0;
        while (!req_ready_0 && n < 20) begin tick(); n++; end
        tick();
        set_req(0, 0, '0, '0, 0);
        n = 0;
        while (!resp_valid_0 && n < 10) begin tick(); n++; end
        resp_ready_1 = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (resp_valid_0 !== 1'b1 || busy !== 1'b1 || resp_data !== 32'h0000_000A) begin errors++; $display("FAIL wrong_owner: got valid0 %b busy %b data %h expected 1 1 0000000a", resp_valid_0, busy, resp_data); end
        end
        resp_ready_1 = 0;
        resp_ready_0 = 1;
        tick();
        resp_ready_0 = 0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL owner_release: got busy %b expected 0", busy); end
    endtask

    task automatic test_random();
        bit v [2]; logic [31:0] fd [2]; logic [4:0] fa [2]; bit fo [2];
        bit last, g, want; int n, hold; logic [31:0] exp;
        reset_dut();
        last = 1;
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 2))
                0: begin v[0] = 1; v[1] = 0; end
                1: begin v[0] = 0; v[1] = 1; end
                default: begin v[0] = 1; v[1] = 1; end
            endcase
            for (int i = 0; i < 2; i++) begin
                fd[i] = $urandom; fa[i] = 5'($urandom_range(0, 31)); fo[i] = 1'($urandom_range(0, 1));
                set_req(1'(i), v[i], fd[i], fa[i], fo[i]);
            end
            want = (v[0] && v[1]) ? ~last : v[1];
            #1;
            checks++; if (req_ready_0 !== (!want) || req_ready_1 !== want) begin errors++; $display("FAIL rand_grant: got ready=%b%b expected requester %0d", req_ready_1, req_ready_0, want); end
            g = want;
            last = want;
            exp = model(fd[g], fa[g], fo[g]);
            tick();
            clear_inputs();
            n = 0;
            while (!(g ? resp_valid_1 : resp_valid_0) && n < 10) begin tick(); n++; end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                if (g) resp_ready_0 = 1'($urandom_range(0, 1)); else resp_ready_1 = 1'($urandom_range(0, 1));
                tick();
            end
            checks++; if ((g ? resp_valid_1 : resp_valid_0) !== 1'b1 || resp_data !== exp) begin errors++; $display("FAIL rand_data: op %0d got %h expected %h", k, resp_data, exp); end
            if (g) resp_ready_1 = 1; else resp_ready_0 = 1;
            tick();
            clear_inputs();
        end
    endtask

    initial begin
        test_reset();
        test_sll_boundary();
        test_round_robin();
        test_sra();
        test_hold();
        test_reset_exec();
        test_wrong_owner();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
